// File: rtl/mread_q.sv
// Queued memory-read stage: issues loads and store read halves to the MMU, matches in-order
// responses to queued operations, and retires results in program order to the write stage.
module mread_q #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              CUSHION_VALID,
    output logic              CUSHION_READY,
    input  logic [4:0]        CUSHION_REG_W_RD,
    input  logic [XLEN-1:0]   CUSHION_REG_W_DATA,
    input  logic [11:0]       CUSHION_CSR_W_ADDR,
    input  logic [XLEN-1:0]   CUSHION_CSR_W_DATA,
    input  logic              CUSHION_MEM_R_VALID,
    input  logic [4:0]        CUSHION_MEM_R_RD,
    input  logic [XLEN-1:0]   CUSHION_MEM_R_ADDR,
    input  logic [1:0]        CUSHION_MEM_R_SIZE,
    input  logic              CUSHION_MEM_R_SIGNED,
    input  logic              CUSHION_MEM_W_VALID,
    input  logic [XLEN-1:0]   CUSHION_MEM_W_ADDR,
    input  logic [1:0]        CUSHION_MEM_W_SIZE,
    input  logic [XLEN-1:0]   CUSHION_MEM_W_DATA,
    input  logic              CUSHION_JMP_DO,
    input  logic [XLEN-1:0]   CUSHION_JMP_PC,
    output logic              DATA_RDEN,
    input  logic              DATA_RREADY,
    output logic [XLEN-1:0]   DATA_RIADDR,
    input  logic              DATA_RVALID,
    input  logic [XLEN-1:0]   DATA_RDATA,
    output logic              MEMR_VALID,
    input  logic              MEMR_READY,
    output logic [4:0]        MEMR_REG_W_RD,
    output logic [XLEN-1:0]   MEMR_REG_W_DATA,
    output logic [11:0]       MEMR_CSR_W_ADDR,
    output logic [XLEN-1:0]   MEMR_CSR_W_DATA,
    output logic              MEMR_JMP_DO,
    output logic [XLEN-1:0]   MEMR_JMP_PC,
    output logic              MEMR_MEM_W_VALID,
    output logic [XLEN-1:0]   MEMR_MEM_W_ADDR,
    output logic [XLEN/8-1:0] MEMR_MEM_W_STRB,
    output logic [XLEN-1:0]   MEMR_MEM_W_DATA,
    output logic              MEMR_MISALIGN
);

    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned OFS = $clog2(NB);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;

    typedef struct packed {
        logic            is_load;
        logic            is_store;
        logic            misalign;
        logic            sgn;
        logic [1:0]      size;
        logic [OFS-1:0]  ofs;
        logic [4:0]      rd;
        logic [XLEN-1:0] reg_data;
        logic [11:0]     csr_addr;
        logic [XLEN-1:0] csr_data;
        logic            jmp_do;
        logic [XLEN-1:0] jmp_pc;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } op_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] reg_data;
        logic [11:0]     csr_addr;
        logic [XLEN-1:0] csr_data;
        logic            jmp_do;
        logic [XLEN-1:0] jmp_pc;
        logic            w_valid;
        logic [XLEN-1:0] w_addr;
        logic [NB-1:0]   strb;
        logic [XLEN-1:0] w_data;
        logic            misalign;
    } res_t;

    function automatic res_t make_res(input op_t op, input logic [XLEN-1:0] word);
        res_t            r;
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] wsh;
        logic [XLEN-1:0] mask;
        logic            sbit;
        int unsigned     nbytes;
        int unsigned     ofs;
        r        = '0;
        sbit     = 1'b0;
        mask     = '0;
        nbytes   = 32'd1 << op.size;
        ofs      = 32'(op.ofs);
        sh       = word >> {op.ofs, 3'b000};
        wsh      = op.wdata << {op.ofs, 3'b000};
        r.rd       = op.rd;
        r.reg_data = op.reg_data;
        r.csr_addr = op.csr_addr;
        r.csr_data = op.csr_data;
        r.jmp_do   = op.jmp_do;
        r.jmp_pc   = op.jmp_pc;
        for (int unsigned b = 0; b < NB; b++) begin
            if (b < nbytes) mask[8*b +: 8] = 8'hff;
            if (b == nbytes - 1) sbit = sh[8*b+7];
        end
        if (op.misalign) begin
            r.rd       = '0;
            r.jmp_do   = 1'b0;
            r.misalign = 1'b1;
        end else if (op.is_load) begin
            r.reg_data = (sh & mask) | ((op.sgn && sbit) ? ~mask : '0);
        end else if (op.is_store) begin
            r.w_valid = 1'b1;
            r.w_addr  = op.addr;
            for (int unsigned b = 0; b < NB; b++) begin
                r.strb[b]         = (b >= ofs) && (b < ofs + nbytes);
                r.w_data[8*b +: 8] = r.strb[b] ? wsh[8*b +: 8] : word[8*b +: 8];
            end
        end
        return r;
    endfunction

    op_t             op_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] pend_q, pend_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d, drop_q, drop_d;
    logic            memr_valid_q, memr_valid_d;
    res_t            res_q, res_d;

    logic            needs_mem, in_mis, misaligned, full, accept, issue;
    logic [XLEN-1:0] m_addr;
    logic [1:0]      m_size;
    op_t             in_op;
    logic            fill_hit, resp_take, head_hit, head_rdy, pop;
    logic [PW-1:0]   fill_idx, idx;
    logic [CW-1:0]   pend_cnt, outstanding;
    op_t             head_op;
    logic [XLEN-1:0] head_word;

    always_comb begin
        needs_mem = CUSHION_MEM_R_VALID | CUSHION_MEM_W_VALID;
        m_addr    = CUSHION_MEM_R_VALID ? CUSHION_MEM_R_ADDR : CUSHION_MEM_W_ADDR;
        m_size    = CUSHION_MEM_R_VALID ? CUSHION_MEM_R_SIZE : CUSHION_MEM_W_SIZE;
        case (m_size)
            2'd0:    in_mis = 1'b0;
            2'd1:    in_mis = m_addr[0];
            2'd2:    in_mis = |m_addr[1:0];
            default: in_mis = (XLEN == 32) || (|m_addr[2:0]);
        endcase
        misaligned = needs_mem & in_mis;
        full       = (count_q == CW'(DEPTH));

        // RST gating keeps the combinational handshakes quiet while in reset.
        CUSHION_READY = RST & !FLUSH & !full
                      & (!needs_mem | misaligned | (DATA_RREADY & (drop_q == '0)));
        DATA_RDEN     = RST & CUSHION_VALID & needs_mem & !misaligned & !FLUSH & !full
                      & (drop_q == '0);
        DATA_RIADDR   = DATA_RDEN ? (m_addr & ~XLEN'(NB - 1)) : '0;
        accept        = CUSHION_VALID & CUSHION_READY;
        issue         = accept & needs_mem & !misaligned;

        in_op          = '0;
        in_op.is_load  = CUSHION_MEM_R_VALID;
        in_op.is_store = CUSHION_MEM_W_VALID & !CUSHION_MEM_R_VALID;
        in_op.misalign = misaligned;
        in_op.sgn      = CUSHION_MEM_R_SIGNED;
        in_op.size     = m_size;
        in_op.ofs      = m_addr[OFS-1:0];
        in_op.rd       = CUSHION_MEM_R_VALID ? CUSHION_MEM_R_RD : CUSHION_REG_W_RD;
        in_op.reg_data = CUSHION_REG_W_DATA;
        in_op.csr_addr = CUSHION_CSR_W_ADDR;
        in_op.csr_data = CUSHION_CSR_W_DATA;
        in_op.jmp_do   = CUSHION_JMP_DO;
        in_op.jmp_pc   = CUSHION_JMP_PC;
        in_op.addr     = m_addr & ~XLEN'(NB - 1);
        in_op.wdata    = CUSHION_MEM_W_DATA;
    end

    // Oldest pending entry in the queue receives the next in-order response.
    always_comb begin
        fill_hit = 1'b0;
        fill_idx = '0;
        pend_cnt = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q && pend_q[idx]) begin
                pend_cnt = pend_cnt + CW'(1);
                if (!fill_hit) begin
                    fill_hit = 1'b1;
                    fill_idx = idx;
                end
            end
        end
        outstanding = drop_q + pend_cnt;
        resp_take   = DATA_RVALID & (drop_q == '0) & fill_hit;
    end

    // The head may bypass straight from this cycle's response or, when empty, from the input.
    always_comb begin
        head_hit = resp_take && (fill_idx == rd_ptr_q);
        if (count_q != '0) begin
            head_op   = op_q[rd_ptr_q];
            head_word = head_hit ? DATA_RDATA : data_q[rd_ptr_q];
            head_rdy  = !pend_q[rd_ptr_q] || head_hit;
        end else begin
            head_op   = in_op;
            head_word = '0;
            head_rdy  = accept & !issue;
        end
        pop = head_rdy & (!memr_valid_q | MEMR_READY) & !FLUSH;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q + PW'(accept);
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        count_d      = count_q + CW'(accept) - CW'(pop);
        pend_d       = pend_q;
        drop_d       = drop_q;
        memr_valid_d = memr_valid_q;
        res_d        = res_q;
        if (resp_take) pend_d[fill_idx] = 1'b0;
        if (accept) pend_d[wr_ptr_q] = issue;
        if (pop) begin
            memr_valid_d = 1'b1;
            res_d        = make_res(head_op, head_word);
        end else if (MEMR_READY) begin
            memr_valid_d = 1'b0;
        end
        if (DATA_RVALID && drop_q != '0) drop_d = drop_q - CW'(1);
        if (FLUSH) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            pend_d       = '0;
            memr_valid_d = 1'b0;
            drop_d       = outstanding - CW'(DATA_RVALID && outstanding != '0);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pend_q       <= '0;
            drop_q       <= '0;
            memr_valid_q <= 1'b0;
            res_q        <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pend_q       <= pend_d;
            drop_q       <= drop_d;
            memr_valid_q <= memr_valid_d;
            res_q        <= res_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) op_q[wr_ptr_q] <= in_op;
        if (resp_take) data_q[fill_idx] <= DATA_RDATA;
    end

    assign MEMR_VALID       = memr_valid_q;
    assign MEMR_REG_W_RD    = res_q.rd;
    assign MEMR_REG_W_DATA  = res_q.reg_data;
    assign MEMR_CSR_W_ADDR  = res_q.csr_addr;
    assign MEMR_CSR_W_DATA  = res_q.csr_data;
    assign MEMR_JMP_DO      = res_q.jmp_do;
    assign MEMR_JMP_PC      = res_q.jmp_pc;
    assign MEMR_MEM_W_VALID = res_q.w_valid;
    assign MEMR_MEM_W_ADDR  = res_q.w_addr;
    assign MEMR_MEM_W_STRB  = res_q.strb;
    assign MEMR_MEM_W_DATA  = res_q.w_data;
    assign MEMR_MISALIGN    = res_q.misalign;

endmodule

// File: tb/tb_mread_q.sv
// Directed bench for mread_q: scoreboard of expected retirements plus point checks on
// handshakes, flush dropping, capacity and reset; a 64-bit instance covers wide loads.
module tb_mread_q;

    logic clk = 1'b0;
    logic rst_n, flush;
    always #5 clk = ~clk;

    logic        c_valid, c_ready, c_r_valid, c_r_signed, c_w_valid, c_jmp_do;
    logic [4:0]  c_reg_rd, c_r_rd;
    logic [11:0] c_csr_addr;
    logic [1:0]  c_r_size, c_w_size;
    logic [31:0] c_reg_data, c_csr_data, c_r_addr, c_w_addr, c_w_data, c_jmp_pc;
    logic        d_rden, d_rready, d_rvalid;
    logic [31:0] d_riaddr, d_rdata;
    logic        m_valid, m_ready, m_jmp_do, m_wv, m_mis;
    logic [4:0]  m_rd;
    logic [11:0] m_csr_addr;
    logic [31:0] m_data, m_csr_data, m_jmp_pc, m_waddr, m_wdata;
    logic [3:0]  m_strb;

    logic        x_valid, x_ready, x_r_valid, x_r_signed, x_rden, x_rvalid, x_m_valid;
    logic [4:0]  x_r_rd, x_m_rd;
    logic [1:0]  x_r_size;
    logic [63:0] x_r_addr, x_riaddr, x_rdata, x_m_data;
    logic [11:0] x_csr_addr_o;
    logic [63:0] x_csr_data_o, x_jmp_pc_o, x_waddr_o, x_wdata_o;
    logic        x_jmp_do_o, x_wv_o, x_mis_o;
    logic [7:0]  x_strb_o;

    mread_q #(.XLEN(32), .DEPTH(4)) u_dut (
        .CLK(clk), .RST(rst_n), .FLUSH(flush),
        .CUSHION_VALID(c_valid), .CUSHION_READY(c_ready),
        .CUSHION_REG_W_RD(c_reg_rd), .CUSHION_REG_W_DATA(c_reg_data),
        .CUSHION_CSR_W_ADDR(c_csr_addr), .CUSHION_CSR_W_DATA(c_csr_data),
        .CUSHION_MEM_R_VALID(c_r_valid), .CUSHION_MEM_R_RD(c_r_rd),
        .CUSHION_MEM_R_ADDR(c_r_addr), .CUSHION_MEM_R_SIZE(c_r_size),
        .CUSHION_MEM_R_SIGNED(c_r_signed),
        .CUSHION_MEM_W_VALID(c_w_valid), .CUSHION_MEM_W_ADDR(c_w_addr),
        .CUSHION_MEM_W_SIZE(c_w_size), .CUSHION_MEM_W_DATA(c_w_data),
        .CUSHION_JMP_DO(c_jmp_do), .CUSHION_JMP_PC(c_jmp_pc),
        .DATA_RDEN(d_rden), .DATA_RREADY(d_rready), .DATA_RIADDR(d_riaddr),
        .DATA_RVALID(d_rvalid), .DATA_RDATA(d_rdata),
        .MEMR_VALID(m_valid), .MEMR_READY(m_ready),
        .MEMR_REG_W_RD(m_rd), .MEMR_REG_W_DATA(m_data),
        .MEMR_CSR_W_ADDR(m_csr_addr), .MEMR_CSR_W_DATA(m_csr_data),
        .MEMR_JMP_DO(m_jmp_do), .MEMR_JMP_PC(m_jmp_pc),
        .MEMR_MEM_W_VALID(m_wv), .MEMR_MEM_W_ADDR(m_waddr),
        .MEMR_MEM_W_STRB(m_strb), .MEMR_MEM_W_DATA(m_wdata), .MEMR_MISALIGN(m_mis)
    );

    mread_q #(.XLEN(64), .DEPTH(4)) u_dut64 (
        .CLK(clk), .RST(rst_n), .FLUSH(1'b0),
        .CUSHION_VALID(x_valid), .CUSHION_READY(x_ready),
        .CUSHION_REG_W_RD(5'd0), .CUSHION_REG_W_DATA(64'd0),
        .CUSHION_CSR_W_ADDR(12'd0), .CUSHION_CSR_W_DATA(64'd0),
        .CUSHION_MEM_R_VALID(x_r_valid), .CUSHION_MEM_R_RD(x_r_rd),
        .CUSHION_MEM_R_ADDR(x_r_addr), .CUSHION_MEM_R_SIZE(x_r_size),
        .CUSHION_MEM_R_SIGNED(x_r_signed),
        .CUSHION_MEM_W_VALID(1'b0), .CUSHION_MEM_W_ADDR(64'd0),
        .CUSHION_MEM_W_SIZE(2'd0), .CUSHION_MEM_W_DATA(64'd0),
        .CUSHION_JMP_DO(1'b0), .CUSHION_JMP_PC(64'd0),
        .DATA_RDEN(x_rden), .DATA_RREADY(1'b1), .DATA_RIADDR(x_riaddr),
        .DATA_RVALID(x_rvalid), .DATA_RDATA(x_rdata),
        .MEMR_VALID(x_m_valid), .MEMR_READY(1'b1),
        .MEMR_REG_W_RD(x_m_rd), .MEMR_REG_W_DATA(x_m_data),
        .MEMR_CSR_W_ADDR(x_csr_addr_o), .MEMR_CSR_W_DATA(x_csr_data_o),
        .MEMR_JMP_DO(x_jmp_do_o), .MEMR_JMP_PC(x_jmp_pc_o),
        .MEMR_MEM_W_VALID(x_wv_o), .MEMR_MEM_W_ADDR(x_waddr_o),
        .MEMR_MEM_W_STRB(x_strb_o), .MEMR_MEM_W_DATA(x_wdata_o), .MEMR_MISALIGN(x_mis_o)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wv;
        logic [31:0] waddr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        mis;
        logic        jmp;
    } exp_t;

    exp_t sb[$];
    exp_t obs, mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   acc;

    assign obs = {m_rd, m_data, m_wv, m_waddr, m_strb, m_wdata, m_mis, m_jmp_do};

    function automatic exp_t mk(input logic [4:0] rd, input logic [31:0] data, input logic wv,
                                input logic [31:0] waddr, input logic [3:0] strb,
                                input logic [31:0] wdata, input logic mis, input logic jmp);
        return {rd, data, wv, waddr, strb, wdata, mis, jmp};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c_valid = 0; c_reg_rd = 0; c_reg_data = 0; c_csr_addr = 0; c_csr_data = 0;
        c_r_valid = 0; c_r_rd = 0; c_r_addr = 0; c_r_size = 0; c_r_signed = 0;
        c_w_valid = 0; c_w_addr = 0; c_w_size = 0; c_w_data = 0; c_jmp_do = 0; c_jmp_pc = 0;
        d_rvalid = 0; d_rdata = 0;
    endtask

    task automatic op_nonmem(input logic [4:0] rd, input logic [31:0] data, input logic jmp);
        idle();
        c_valid = 1; c_reg_rd = rd; c_reg_data = data; c_jmp_do = jmp; c_jmp_pc = 32'h80;
    endtask

    task automatic op_load(input logic [4:0] rd, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn);
        idle();
        c_valid = 1; c_r_valid = 1; c_r_rd = rd; c_r_addr = addr; c_r_size = size;
        c_r_signed = sgn;
    endtask

    // One memory op with a single-cycle response; result must appear the cycle after.
    task automatic mem_op(input logic st, input logic [4:0] rd, input logic [31:0] addr,
                          input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                          input logic [31:0] rdata, input exp_t e);
        if (st) begin
            idle();
            c_valid = 1; c_w_valid = 1; c_w_addr = addr; c_w_size = size; c_w_data = wdata;
        end else begin
            op_load(rd, addr, size, sgn);
        end
        @(negedge clk);
        chk("mem_ready", c_ready, 1'b1);
        chk("mem_rden", d_rden, 1'b1);
        chk("mem_riaddr", d_riaddr, addr & 32'hFFFF_FFFC);
        sb.push_back(e);
        step();
        idle();
        d_rvalid = 1; d_rdata = rdata;
        step();
        d_rvalid = 0;
        @(negedge clk);
        chk("mem_latency", m_valid, 1'b1);
        step();
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            step();
            t++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", m_valid, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                chk("memr_out", obs, mon_e);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1; flush = 0; m_ready = 1; d_rready = 1; idle();
        x_valid = 0; x_r_valid = 0; x_r_rd = 0; x_r_addr = 0; x_r_size = 0; x_r_signed = 0;
        x_rvalid = 0; x_rdata = 0;
        #1 rst_n = 0;
        op_nonmem(5'd3, 32'h55, 1'b1);
        #2;
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_rd", m_rd, 5'd0);
        chk("rst_data", m_data, 32'd0);
        chk("rst_ready", c_ready, 1'b0);
        chk("rst_rden", d_rden, 1'b0);
        chk("rst_riaddr", d_riaddr, 32'd0);
        step();
        step();
        rst_n = 1;
        idle();
        step();

        mem_op(1'b0, 5'd5, 32'h1003, 2'd0, 1'b1, 32'd0, 32'h8A00_0000,
               mk(5'd5, 32'hFFFF_FF8A, 0, 0, 0, 0, 0, 0));
        mem_op(1'b0, 5'd6, 32'h1003, 2'd0, 1'b0, 32'd0, 32'h8A00_0000,
               mk(5'd6, 32'h0000_008A, 0, 0, 0, 0, 0, 0));
        mem_op(1'b1, 5'd0, 32'h2002, 2'd1, 1'b0, 32'h1234, 32'hAABB_CCDD,
               mk(5'd0, 32'd0, 1, 32'h2000, 4'b1100, 32'h1234_CCDD, 0, 0));
        drain(3);

        // Misaligned word load: no MMU request, dropped result next cycle.
        op_load(5'd7, 32'h1002, 2'd2, 1'b0);
        c_jmp_do = 1;
        @(negedge clk);
        chk("mis_rden", d_rden, 1'b0);
        chk("mis_ready", c_ready, 1'b1);
        sb.push_back(mk(5'd0, 32'd0, 0, 0, 0, 0, 1, 0));
        step();
        idle();
        @(negedge clk);
        chk("mis_latency", m_valid, 1'b1);
        step();
        drain(3);

        // Load followed by a non-memory op accepted in the same cycle as the response.
        op_load(5'd9, 32'h3000, 2'd2, 1'b0);
        @(negedge clk);
        sb.push_back(mk(5'd9, 32'hCAFE_BABE, 0, 0, 0, 0, 0, 0));
        step();
        op_nonmem(5'd4, 32'h44, 1'b1);
        d_rvalid = 1; d_rdata = 32'hCAFE_BABE;
        @(negedge clk);
        chk("order_ready", c_ready, 1'b1);
        sb.push_back(mk(5'd4, 32'h44, 0, 0, 0, 0, 0, 1));
        step();
        idle();
        drain(4);

        // Capacity: DEPTH queued plus the output register.
        m_ready = 0;
        acc = 0;
        for (int i = 1; i <= 6; i++) begin
            op_nonmem(5'(i), 32'h100 + 32'(i), 1'b0);
            @(negedge clk);
            if (c_ready) begin
                sb.push_back(mk(5'(i), 32'h100 + 32'(i), 0, 0, 0, 0, 0, 0));
                acc++;
            end
            step();
        end
        chk("cap_accepted", 32'(acc), 32'd5);
        @(negedge clk);
        chk("cap_full_ready", c_ready, 1'b0);
        chk("cap_head_rd", m_rd, 5'd1);
        step();
        idle();
        m_ready = 1;
        drain(5);

        // Flush with two reads outstanding; their responses must be discarded.
        op_load(5'd10, 32'h4000, 2'd2, 1'b0);
        @(negedge clk);
        chk("fl_rden1", d_rden, 1'b1);
        step();
        op_load(5'd11, 32'h4004, 2'd2, 1'b0);
        @(negedge clk);
        chk("fl_rden2", d_rden, 1'b1);
        step();
        idle();
        flush = 1;
        @(negedge clk);
        chk("fl_ready", c_ready, 1'b0);
        step();
        flush = 0;
        op_load(5'd12, 32'h4008, 2'd2, 1'b0);
        d_rvalid = 1; d_rdata = 32'h11;
        @(negedge clk);
        chk("fl_drop_rden1", d_rden, 1'b0);
        step();
        d_rdata = 32'h22;
        @(negedge clk);
        chk("fl_drop_rden2", d_rden, 1'b0);
        step();
        d_rvalid = 0;
        @(negedge clk);
        chk("fl_rden3", d_rden, 1'b1);
        sb.push_back(mk(5'd12, 32'h33, 0, 0, 0, 0, 0, 0));
        step();
        idle();
        d_rvalid = 1; d_rdata = 32'h33;
        step();
        d_rvalid = 0;
        drain(4);
        step();

        // 64-bit signed word load from the upper half of a doubleword.
        x_valid = 1; x_r_valid = 1; x_r_rd = 5'd3; x_r_addr = 64'h14; x_r_size = 2'd2;
        x_r_signed = 1;
        @(negedge clk);
        chk("x_rden", x_rden, 1'b1);
        chk("x_riaddr", x_riaddr, 64'h10);
        step();
        x_valid = 0; x_r_valid = 0;
        x_rvalid = 1; x_rdata = 64'h8000_0001_0000_0000;
        step();
        x_rvalid = 0;
        @(negedge clk);
        chk("x_valid", x_m_valid, 1'b1);
        chk("x_data", x_m_data, 64'hFFFF_FFFF_8000_0001);
        chk("x_rd", x_m_rd, 5'd3);
        step();

        // Reset asserted mid-stream clears every output at once.
        m_ready = 0;
        op_nonmem(5'd20, 32'hAB, 1'b1);
        step();
        op_load(5'd21, 32'h5000, 2'd2, 1'b0);
        @(negedge clk);
        chk("mid_valid", m_valid, 1'b1);
        chk("mid_rden", d_rden, 1'b1);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_valid", m_valid, 1'b0);
        chk("mid_rst_rd", m_rd, 5'd0);
        chk("mid_rst_data", m_data, 32'd0);
        chk("mid_rst_jmp", m_jmp_do, 1'b0);
        chk("mid_rst_rden", d_rden, 1'b0);
        chk("mid_rst_riaddr", d_riaddr, 32'd0);
        chk("mid_rst_ready", c_ready, 1'b0);
        idle();
        step();
        rst_n = 1;
        m_ready = 1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
